// File: rtl/buf_scheduler.sv
// ============================================================================
// buf_scheduler : four 6-deep queues drained one entry per tick
// Rev 1.0
// ============================================================================
`default_nettype none

module buf_scheduler #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [1:0] wr_data,
  output logic [1:0] disp,
  output logic       disp_valid,
  output logic [1:0] disp_src,
  output logic [2:0] L1,
  output logic [2:0] L2,
  output logic [2:0] L3,
  output logic [2:0] L4,
  output logic       drop
);

  localparam int          c_nq    = 4;
  localparam int          c_depth = 6;
  localparam logic [2:0]  c_full  = 3'd6;
  localparam logic [2:0]  c_limit = 3'(STARVE_LIMIT);

  // Entry 0 of each queue is always the head; pops shift toward it.
  logic [1:0] r_mem    [c_nq][c_depth];
  logic       r_vld    [c_nq][c_depth];
  logic [2:0] r_occ    [c_nq];
  logic [2:0] r_starve [c_nq];

  logic [1:0] w_mem    [c_nq][c_depth];
  logic       w_vld    [c_nq][c_depth];
  logic [2:0] w_occ    [c_nq];
  logic [2:0] w_starve [c_nq];
  logic       w_pop    [c_nq];
  logic       w_push   [c_nq];
  logic [2:0] w_pos    [c_nq];

  logic       w_any;
  logic [1:0] w_sel;
  logic       w_starve_hit;
  logic [1:0] w_starve_idx;
  logic [1:0] w_hi_idx;
  logic [1:0] w_big_idx;
  logic [2:0] w_big_occ;
  logic       w_drop;

  always_comb begin
    w_any        = 1'b0;
    w_starve_hit = 1'b0;
    w_starve_idx = 2'd0;
    w_hi_idx     = 2'd0;
    w_big_idx    = 2'd0;
    w_big_occ    = 3'd0;
    for (int i = c_nq - 1; i >= 0; i--) begin
      if (r_occ[i] != 3'd0 && r_starve[i] >= c_limit) begin
        w_starve_hit = 1'b1;
        w_starve_idx = 2'(i);
      end
    end
    for (int i = 0; i < c_nq; i++) begin
      if (r_occ[i] != 3'd0) begin
        w_any    = 1'b1;
        w_hi_idx = 2'(i);
      end
      // Strict compare keeps the lowest index on ties.
      if (r_occ[i] > w_big_occ) begin
        w_big_occ = r_occ[i];
        w_big_idx = 2'(i);
      end
    end
    if (w_starve_hit) begin
      w_sel = w_starve_idx;
    end else if (mode) begin
      w_sel = w_hi_idx;
    end else begin
      w_sel = w_big_idx;
    end
  end

  always_comb begin
    for (int q = 0; q < c_nq; q++) begin
      w_mem[q]    = r_mem[q];
      w_vld[q]    = r_vld[q];
      w_starve[q] = r_starve[q];
      w_pop[q]    = tick && w_any && (w_sel == 2'(q));
      w_push[q]   = wr_en && (wr_sel == 2'(q)) && ((r_occ[q] != c_full) || w_pop[q]);
      w_pos[q]    = w_pop[q] ? (r_occ[q] - 3'd1) : r_occ[q];
      if (w_pop[q]) begin
        for (int j = 0; j < c_depth - 1; j++) begin
          w_mem[q][j] = r_mem[q][j+1];
          w_vld[q][j] = r_vld[q][j+1];
        end
        w_mem[q][c_depth-1] = 2'd0;
        w_vld[q][c_depth-1] = 1'b0;
      end
      if (w_push[q]) begin
        w_mem[q][w_pos[q]] = wr_data;
        w_vld[q][w_pos[q]] = 1'b1;
      end
      w_occ[q] = r_occ[q] + {2'b00, w_push[q]} - {2'b00, w_pop[q]};
      if (tick && w_any) begin
        if (w_pop[q] || r_occ[q] == 3'd0) begin
          w_starve[q] = 3'd0;
        end else if (r_starve[q] != 3'd7) begin
          w_starve[q] = r_starve[q] + 3'd1;
        end
      end
    end
    w_drop = wr_en && (r_occ[wr_sel] == c_full) && !w_pop[wr_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < c_nq; q++) begin
        for (int j = 0; j < c_depth; j++) begin
          r_mem[q][j] <= 2'd0;
          r_vld[q][j] <= 1'b0;
        end
        r_occ[q]    <= 3'd0;
        r_starve[q] <= 3'd0;
      end
      disp       <= 2'd0;
      disp_src   <= 2'd0;
      disp_valid <= 1'b0;
      drop       <= 1'b0;
    end else begin
      for (int q = 0; q < c_nq; q++) begin
        for (int j = 0; j < c_depth; j++) begin
          r_mem[q][j] <= w_mem[q][j];
          r_vld[q][j] <= w_vld[q][j];
        end
        r_occ[q]    <= w_occ[q];
        r_starve[q] <= w_starve[q];
      end
      drop       <= w_drop;
      disp_valid <= tick && w_any;
      if (tick && w_any) begin
        disp     <= r_mem[w_sel][0];
        disp_src <= w_sel;
      end
    end
  end

  assign L1 = r_occ[0];
  assign L2 = r_occ[1];
  assign L3 = r_occ[2];
  assign L4 = r_occ[3];

endmodule

`default_nettype wire

// File: doc/buf_scheduler.md
BUF_SCHEDULER -- requirements
Module: buf_scheduler

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning the number of ticks a non-empty queue may go unserved before it is forced; legal range 1..7.
REQ-002 SHALL have input clk, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have input rst, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have input tick, 1 bit: one-cycle drain strobe from the frequency divider.
REQ-005 SHALL have input mode, 1 bit: 1 = reliability, 0 = latency.
REQ-006 SHALL have input wr_en, 1 bit: write strobe.
REQ-007 SHALL have input wr_sel, 2 bits: target queue, 0..3 for queue 1..4.
REQ-008 SHALL have input wr_data, 2 bits: payload.
REQ-009 SHALL have output disp, 2 bits: last dispatched payload (registered).
REQ-010 SHALL have output disp_valid, 1 bit: one-cycle pulse marking a dispatch.
REQ-011 SHALL have output disp_src, 2 bits: queue index of the last dispatch.
REQ-012 SHALL have outputs L1, L2, L3, L4, 3 bits each: occupancy of queues 1..4, range 0..6.
REQ-013 SHALL have output drop, 1 bit: one-cycle pulse when a write is rejected.

Function
REQ-014 SHALL hold four independent FIFOs, each 6 entries deep and 2 bits wide, with each entry stored with a valid bit.
REQ-015 SHALL accept a write only when wr_en=1 and the target queue occupancy is below 6, appending at the tail.
REQ-016 SHALL reject a write to a full queue, leave that queue unchanged, and pulse drop in the following cycle.
REQ-017 SHALL do nothing on a tick when all queues are empty: no dispatch, disp_valid=0, disp and disp_src held.
REQ-018 SHALL perform a dispatch on a tick when any queue is non-empty: pop the head of exactly one selected queue.
REQ-019 SHALL register the dispatch so that disp, disp_src and disp_valid=1 appear in the cycle after the tick (latency 1); disp_valid SHALL be 0 in all other cycles.
REQ-020 SHALL use as selection inputs the occupancies sampled in the tick cycle, i.e. before any same-cycle write.
REQ-021 SHALL apply selection priority 1 (starvation): if any non-empty queue has starve_cnt >= STARVE_LIMIT, select the lowest-index such queue.
REQ-022 SHALL apply selection priority 2 in latency mode (mode=0): select the non-empty queue with the largest occupancy; ties go to the lowest index.
REQ-023 SHALL apply selection priority 2 in reliability mode (mode=1): select the highest-index non-empty queue (4 > 3 > 2 > 1).
REQ-024 SHALL keep a 3-bit starve_cnt per queue; on each tick with a dispatch, the served queue and every empty queue clear to 0, and every other non-empty queue increments, saturating at 7.
REQ-025 SHALL, on a write and a pop to the same queue in the same cycle, perform both, leaving occupancy unchanged and keeping FIFO order; a write to a full queue that is popped in the same cycle SHALL be accepted.
REQ-026 SHALL sample mode only on tick cycles; a mode change between ticks has no effect.
REQ-027 SHALL pop exactly one entry per tick; ticks on consecutive cycles are each serviced.
REQ-028 SHALL drive L1..L4 as registered occupancies, reflecting writes and pops one cycle after they occur.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear all FIFOs, occupancies, starve counters, disp, disp_src, disp_valid and drop to 0.
REQ-030 SHALL give rst priority over tick and wr_en in the same cycle; a reset mid-operation discards all queued data.
REQ-031 SHALL resume normal operation on the first edge with rst=0.

Verification
REQ-032 SHALL pass this scenario: write queue1 {1,2}, then a tick with mode=0 -> next cycle disp=1, disp_src=0, disp_valid=1, L1=1.
REQ-033 SHALL pass this scenario: fill queue3 to 6 entries, then write queue3 once more -> drop pulses once, L3 stays 6; repeat with a tick in the same cycle -> no drop, L3 stays 6.
REQ-034 SHALL pass this scenario: L1=2, L2=4, L4=4 with mode=0 -> queue2 served; the same state with mode=1 -> queue4 served.
REQ-035 SHALL pass this scenario: mode=1, STARVE_LIMIT=3, queue1 and queue4 each with 6 entries -> ticks 1-3 serve queue4 and tick 4 serves queue1 (starve_cnt1=3), after which starve_cnt1=0.
REQ-036 SHALL pass this scenario: all queues empty, then a tick -> disp_valid stays 0 and disp and disp_src are unchanged.
REQ-037 SHALL pass this scenario: rst asserted with a tick pending on a non-empty queue -> next cycle all outputs are 0, no dispatch occurs, and L1..L4=0.
